uart_tx_arbiter: RTL and testbench

//  Shares the single uart_controller byte stream between two requesters (0: CPU core, 1: debug/loader).
//  TX: round-robin, packet-locked arbitration of two AXI4-stream byte sources onto UART_WRITE, with a registered output.
//  RX: routes the UART_READ stream to one owner selected by RX_SEL; the selection changes only between bytes.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 15 +
 rtl/uart_rr_pick2.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART sharing logic: byte width, requester
// indices, the TX arbiter state encoding and a grant one-hot helper.
package uart_pkg;

    localparam int          DATA_W         = 8;
    localparam logic        REQ_CORE       = 1'b0;
    localparam logic        REQ_DBG        = 1'b1;
    localparam logic [31:0] UART_BASE_ADDR = 32'h4000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } tx_state_e;

    function automatic logic [1:0] req_onehot(input logic req);
        return (req == REQ_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// AXI4-stream style byte channel used for every stream around the arbiter.
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid/tlast, drives tready
interface uart_tx_arbiter_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/uart_rr_pick2.sv
// Two-way round-robin pick. The requester that did not own the last grant
// wins when it is valid; otherwise the only valid requester wins.
//   valid_i[1:0]  request valid per requester
//   last_grant_i  index of the previous owner
//   any_o         at least one request present
//   winner_o      index of the selected requester (meaningful when any_o)
module uart_rr_pick2
    import uart_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       any_o,
    output logic       winner_o
);

    logic other;

    assign other = ~last_grant_i;
    assign any_o = |valid_i;

    always_comb begin
        winner_o = REQ_CORE;
        if (valid_i[other]) begin
            winner_o = other;
        end else if (valid_i[last_grant_i]) begin
            winner_o = last_grant_i;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_controller byte stream between the CPU core (0) and the
// debug/loader (1).
//   TX: packet-locked round-robin of s0/s1 onto m through a registered byte
//       slot; a grant ends on TLAST or after MAX_BURST bytes.
//   RX: r is routed to rx0 or rx1; the owner follows rx_sel_i only while no
//       byte is pending on r.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   s0, s1       requester TX byte streams (slave)
//   m            stream to UART_WRITE (master, registered)
//   r            stream from UART_READ (slave)
//   rx0, rx1     requester RX byte streams (master)
//   rx_sel_i     requested RX owner
//   grant_o      one-hot TX owner, 00 while idle
//   busy_o       TX locked or output byte still pending
//
// state   | meaning
// ST_IDLE | no owner; arbitrate among valid requesters
// ST_LOCK | owner in gnt_q forwards bytes until TLAST or burst cap
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_arbiter_if.slave         s0,
    uart_tx_arbiter_if.slave         s1,
    uart_tx_arbiter_if.master        m,
    uart_tx_arbiter_if.slave         r,
    uart_tx_arbiter_if.master        rx0,
    uart_tx_arbiter_if.master        rx1,
    input  logic                     rx_sel_i,
    output logic [1:0]               grant_o,
    output logic                     busy_o
);

    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    tx_state_e         state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic              rx_owner_q, rx_owner_d;

    logic              pick_any, pick_winner;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              slot_free, accept, release_gnt;

    uart_rr_pick2 u_pick (
        .valid_i      ({s1.tvalid, s0.tvalid}),
        .last_grant_i (last_grant_q),
        .any_o        (pick_any),
        .winner_o     (pick_winner)
    );

    assign sel_valid   = gnt_q ? s1.tvalid : s0.tvalid;
    assign sel_data    = gnt_q ? s1.tdata  : s0.tdata;
    assign sel_last    = gnt_q ? s1.tlast  : s0.tlast;
    // The slot takes a new byte when empty or emptying this cycle; this keeps
    // m.tvalid purely registered.
    assign slot_free   = (state_q == ST_LOCK) && (!m_tvalid_q || m.tready);
    assign accept      = slot_free && sel_valid;
    assign release_gnt = accept && (sel_last || (beat_cnt_q == LAST_BEAT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= REQ_CORE;
            last_grant_q <= REQ_DBG;
            beat_cnt_q   <= '0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            rx_owner_q   <= REQ_CORE;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            rx_owner_q   <= rx_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_LOCK;
                    gnt_d      = pick_winner;
                    beat_cnt_d = '0;
                end
            end
            ST_LOCK: begin
                if (release_gnt) begin
                    state_d      = ST_IDLE;
                    last_grant_d = gnt_q;
                    beat_cnt_d   = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot drains independently of the FSM state.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        if (accept) begin
            m_tdata_d  = sel_data;
            m_tvalid_d = 1'b1;
            m_tlast_d  = sel_last;
        end else if (m_tvalid_q && m.tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_comb begin
        s0.tready = slot_free && (gnt_q == REQ_CORE);
        s1.tready = slot_free && (gnt_q == REQ_DBG);
        grant_o   = (state_q == ST_LOCK) ? req_onehot(gnt_q) : 2'b00;
        busy_o    = (state_q == ST_LOCK) || m_tvalid_q;
    end

    assign m.tdata  = m_tdata_q;
    assign m.tvalid = m_tvalid_q;
    assign m.tlast  = m_tlast_q;

    // RX owner only moves between bytes so a pending byte is never rerouted.
    assign rx_owner_d = r.tvalid ? rx_owner_q : rx_sel_i;

    assign rx0.tdata  = r.tdata;
    assign rx0.tlast  = r.tlast;
    assign rx0.tvalid = r.tvalid && (rx_owner_q == REQ_CORE);
    assign rx1.tdata  = r.tdata;
    assign rx1.tlast  = r.tlast;
    assign rx1.tvalid = r.tvalid && (rx_owner_q == REQ_DBG);
    assign r.tready   = rx_owner_q ? rx1.tready : rx0.tready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_sel = 1'b0;
    logic [1:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter_if s0 ();
    uart_tx_arbiter_if s1 ();
    uart_tx_arbiter_if m ();
    uart_tx_arbiter_if r ();
    uart_tx_arbiter_if rx0 ();
    uart_tx_arbiter_if rx1 ();

    uart_tx_arbiter #(.MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0       (s0),
        .s1       (s1),
        .m        (m),
        .r        (r),
        .rx0      (rx0),
        .rx1      (rx1),
        .rx_sel_i (rx_sel),
        .grant_o  (grant),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] got[$];
    always @(posedge clk) begin
        if (rst_n && m.tvalid && m.tready) got.push_back(m.tdata);
    end

    logic [7:0] sd[2][16];
    bit         sl[2][16];
    int         sn[2];
    int         sp[2];
    int         sst[2];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s0.tvalid = 0; s0.tdata = 0; s0.tlast = 0;
        s1.tvalid = 0; s1.tdata = 0; s1.tlast = 0;
        m.tready = 1; r.tvalid = 0; r.tdata = 0; r.tlast = 0;
        rx0.tready = 0; rx1.tready = 0; rx_sel = 0;
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        sn[0] = 0; sn[1] = 0; sp[0] = 0; sp[1] = 0; sst[0] = 0; sst[1] = 0;
    endtask

    task automatic drive_srcs(input int cyc);
        s0.tvalid = (cyc >= sst[0]) && (sp[0] < sn[0]);
        s0.tdata  = (sp[0] < sn[0]) ? sd[0][sp[0]] : 8'h00;
        s0.tlast  = (sp[0] < sn[0]) ? sl[0][sp[0]] : 1'b0;
        s1.tvalid = (cyc >= sst[1]) && (sp[1] < sn[1]);
        s1.tdata  = (sp[1] < sn[1]) ? sd[1][sp[1]] : 8'h00;
        s1.tlast  = (sp[1] < sn[1]) ? sl[1][sp[1]] : 1'b0;
    endtask

    task automatic run_sources(input string name, input int budget,
                               input int stall_from, input int stall_len);
        int cyc;
        bit f0, f1, done;
        cyc = 0;
        done = 0;
        while (cyc < budget && !done) begin
            drive_srcs(cyc);
            m.tready = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
            #3;
            if (!m.tready && m.tvalid)
                chk({name, "_stall_tready"}, {30'd0, s1.tready, s0.tready}, 32'd0);
            f0 = s0.tvalid && s0.tready;
            f1 = s1.tvalid && s1.tready;
            tick();
            if (f0) sp[0]++;
            if (f1) sp[1]++;
            cyc++;
            done = (sp[0] >= sn[0]) && (sp[1] >= sn[1]) && !m.tvalid;
        end
        chk({name, "_done_in_budget"}, {31'd0, done}, 32'd1);
        s0.tvalid = 0; s1.tvalid = 0; m.tready = 1;
    endtask

    task automatic cmp_stream(input string name);
        logic [31:0] obs;
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got.size()) ? {24'd0, got[i]} : 32'hxxxx_xxxx;
            chk($sformatf("%s_byte%0d", name, i), obs, {24'd0, exp_q[i]});
        end
    endtask

    task automatic add_src(input int s, input logic [7:0] d, input bit last);
        sd[s][sn[s]] = d;
        sl[s][sn[s]] = last;
        sn[s]++;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_m_tvalid", {31'd0, m.tvalid}, 32'd0);
        chk("rst_m_tdata", {24'd0, m.tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_s_tready", {30'd0, s1.tready, s0.tready}, 32'd0);

        // 1: single byte, grant at t+1, M_TVALID at t+2
        s0.tdata = 8'h41; s0.tlast = 1; s0.tvalid = 1; m.tready = 1;
        tick();
        chk("t1_grant", {30'd0, grant}, 32'h1);
        chk("t1_s0_tready", {31'd0, s0.tready}, 32'd1);
        chk("t1_s1_tready", {31'd0, s1.tready}, 32'd0);
        chk("t1_m_tvalid_early", {31'd0, m.tvalid}, 32'd0);
        tick();
        s0.tvalid = 0; s0.tlast = 0;
        chk("t1_m_tvalid", {31'd0, m.tvalid}, 32'd1);
        chk("t1_m_tdata", {24'd0, m.tdata}, 32'h41);
        chk("t1_grant_released", {30'd0, grant}, 32'd0);
        chk("t1_busy_draining", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_m_drained", {31'd0, m.tvalid}, 32'd0);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        chk("t1_count", got.size(), 32'd1);

        // 2: contention from reset, 3-byte packets alternate starting with S0
        do_reset();
        add_src(0, 8'hA0, 0); add_src(0, 8'hA1, 0); add_src(0, 8'hA2, 1);
        add_src(0, 8'hA3, 0); add_src(0, 8'hA4, 0); add_src(0, 8'hA5, 1);
        add_src(1, 8'hB0, 0); add_src(1, 8'hB1, 0); add_src(1, 8'hB2, 1);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hA3, 8'hA4, 8'hA5};
        run_sources("t2", 100, 1000, 0);
        cmp_stream("t2");

        // 3: burst cap of 4, S1 streams 10 bytes without TLAST, S0 joins later
        do_reset();
        for (int i = 0; i < 10; i++) add_src(1, 8'hD0 + 8'(i), 0);
        add_src(0, 8'hC0, 0); add_src(0, 8'hC1, 1);
        sst[0] = 2;
        exp_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hC0, 8'hC1,
                  8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9};
        run_sources("t3", 100, 1000, 0);
        cmp_stream("t3");
        chk("t3_grant_held", {30'd0, grant}, 32'h2);

        // 4: backpressure, M_TREADY low 5 cycles while a byte is held
        do_reset();
        for (int i = 0; i < 3; i++) add_src(0, 8'hE0 + 8'(i), 0);
        add_src(0, 8'hE3, 0); add_src(0, 8'hE4, 1);
        exp_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        run_sources("t4", 100, 3, 5);
        cmp_stream("t4");

        // 5: RX owner switch only between bytes
        do_reset();
        rx1.tready = 1; rx0.tready = 0; rx_sel = 0;
        tick();
        r.tdata = 8'h5A; r.tvalid = 1;
        #1;
        chk("t5_rx0_tvalid", {31'd0, rx0.tvalid}, 32'd1);
        chk("t5_rx1_tvalid", {31'd0, rx1.tvalid}, 32'd0);
        chk("t5_r_tready_blocked", {31'd0, r.tready}, 32'd0);
        rx_sel = 1;
        tick();
        tick();
        chk("t5_rx0_hold", {31'd0, rx0.tvalid}, 32'd1);
        chk("t5_rx1_hold", {31'd0, rx1.tvalid}, 32'd0);
        chk("t5_rx0_tdata", {24'd0, rx0.tdata}, 32'h5A);
        rx0.tready = 1;
        #1;
        chk("t5_r_tready", {31'd0, r.tready}, 32'd1);
        tick();
        r.tvalid = 0;
        tick();
        r.tdata = 8'hA5; r.tvalid = 1; rx0.tready = 0;
        #1;
        chk("t5_next_rx1_tvalid", {31'd0, rx1.tvalid}, 32'd1);
        chk("t5_next_rx0_tvalid", {31'd0, rx0.tvalid}, 32'd0);
        chk("t5_next_rx1_tdata", {24'd0, rx1.tdata}, 32'hA5);
        chk("t5_next_r_tready", {31'd0, r.tready}, 32'd1);
        r.tvalid = 0;

        // 6: reset during S1 byte 2
        do_reset();
        s1.tdata = 8'hF0; s1.tlast = 0; s1.tvalid = 1; m.tready = 1;
        tick();
        chk("t6_grant_s1", {30'd0, grant}, 32'h2);
        tick();
        chk("t6_m_tdata", {24'd0, m.tdata}, 32'hF0);
        chk("t6_m_tvalid", {31'd0, m.tvalid}, 32'd1);
        s1.tdata = 8'hF1;
        s0.tdata = 8'h11; s0.tlast = 1; s0.tvalid = 1;
        rst_n = 0;
        tick();
        chk("t6_rst_m_tvalid", {31'd0, m.tvalid}, 32'd0);
        chk("t6_rst_grant", {30'd0, grant}, 32'd0);
        rst_n = 1;
        tick();
        chk("t6_first_win_s0", {30'd0, grant}, 32'h1);
        s0.tvalid = 0; s1.tvalid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
